// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential saturating multiply-accumulate front end of a neuron.
// Ports:
//    clk, rst                  clock (rising edge), asynchronous active-high reset
//    start, bias               begin a job in IDLE; bias captured on that start
//    in_valid, in_ready        x_in/w_in pair handshake, one pair per cycle at most
//    x_in, w_in                signed 8-bit activation and weight
//    acc_out, bias_out         registered saturated sum and captured bias
//    out_valid, out_ready      result handshake towards the bias adder
//    overflow                  sticky saturation flag for the current job
//    busy                      high while a job is accumulating or waiting to be taken
module neuron_mac_seq #(
   parameter int N_INPUTS = 4,
   localparam int CNT_W = $clog2(N_INPUTS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [7:0]  bias,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [7:0]  x_in,
   input  logic signed [7:0]  w_in,
   output logic signed [15:0] acc_out,
   output logic signed [7:0]  bias_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               overflow,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic signed [15:0] prod;
   logic [16:0] sum;
   logic pos_ov, neg_ov;
   logic signed [15:0] sat;
   always_comb begin
      prod = x_in * w_in;
      sum = {acc_out[15], acc_out} + {prod[15], prod};
      // top two bits of the 17-bit sum disagree only when it left the 16-bit range
      pos_ov = sum[16:15] == 2'b01;
      neg_ov = sum[16:15] == 2'b10;
      sat = pos_ov ? 16'sh7fff : neg_ov ? -16'sh8000 : sum[15:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         acc_out <= '0;
         bias_out <= '0;
         overflow <= 1'b0;
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= ACCUM;
               cnt <= '0;
               acc_out <= '0;
               overflow <= 1'b0;
               bias_out <= bias;
               in_ready <= 1'b1;
               busy <= 1'b1;
            end
            ACCUM: if (in_valid) begin
               acc_out <= sat;
               overflow <= overflow | pos_ov | neg_ov;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(N_INPUTS - 1)) begin
                  state <= DONE;
                  in_ready <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state <= IDLE;
               out_valid <= 1'b0;
               busy <= 1'b0;
            end
            default: begin
               state <= IDLE;
               in_ready <= 1'b0;
               out_valid <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: table-driven and random checks of neuron_mac_seq against a saturating reference model.
module tb_neuron_mac_seq;
   typedef struct packed {
      logic signed [7:0] b;
      logic [3:0][7:0]   x;
      logic [3:0][7:0]   w;
      int                acc;
      int                ov;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic signed [7:0] bias = '0, x_in = '0, w_in = '0;
   logic in_ready, out_valid, overflow, busy;
   logic signed [15:0] acc_out;
   logic signed [7:0] bias_out;
   int total = 0, bad = 0;
   vec_t tbl[6];

   neuron_mac_seq dut (
      .clk(clk), .rst(rst), .start(start), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
      .acc_out(acc_out), .bias_out(bias_out), .out_valid(out_valid),
      .out_ready(out_ready), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Saturating running sum of the first n pairs, clamped after every step.
   task automatic ref_model(input vec_t v, input int n, output int acc, output int ov);
      acc = 0;
      ov = 0;
      for (int i = 0; i < n; i++) begin
         int xi, wi;
         xi = $signed(v.x[i]);
         wi = $signed(v.w[i]);
         acc = acc + xi * wi;
         if (acc > 32767) begin acc = 32767; ov = 1; end
         if (acc < -32768) begin acc = -32768; ov = 1; end
      end
   endtask

   function automatic vec_t mk(input int b, x0, x1, x2, x3, w0, w1, w2, w3, acc, ov);
      vec_t v;
      v.b = b[7:0];
      v.x[0] = x0[7:0]; v.x[1] = x1[7:0]; v.x[2] = x2[7:0]; v.x[3] = x3[7:0];
      v.w[0] = w0[7:0]; v.w[1] = w1[7:0]; v.w[2] = w2[7:0]; v.w[3] = w3[7:0];
      v.acc = acc;
      v.ov = ov;
      return v;
   endfunction

   task automatic start_job(input logic signed [7:0] b);
      @(negedge clk);
      start = 1'b1;
      bias = b;
      @(negedge clk);
      start = 1'b0;
      bias = 8'($urandom);
      chk("start_in_ready", int'(in_ready), 1);
      chk("start_busy", int'(busy), 1);
      chk("start_acc_clr", int'(acc_out), 0);
      chk("start_ov_clr", int'(overflow), 0);
      chk("start_bias", int'(bias_out), int'(b));
   endtask

   task automatic feed(input logic [7:0] x, w, input int gap);
      repeat (gap) begin
         in_valid = 1'b0;
         x_in = 8'($urandom);
         w_in = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      x_in = x;
      w_in = w;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic take(input int stall, input int exp_acc, input int exp_ov, input int b);
      repeat (stall) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
         chk("hold_acc", int'(acc_out), exp_acc);
         chk("hold_ov", int'(overflow), exp_ov);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_valid", int'(out_valid), 0);
      chk("drain_busy", int'(busy), 0);
      chk("idle_acc", int'(acc_out), exp_acc);
      chk("idle_bias", int'(bias_out), b);
      chk("idle_ov", int'(overflow), exp_ov);
   endtask

   task automatic accumulate(input vec_t v, input int gapmax);
      int e, o;
      for (int i = 0; i < 4; i++) begin
         feed(v.x[i], v.w[i], $urandom_range(0, gapmax));
         ref_model(v, i + 1, e, o);
         chk("run_acc", int'(acc_out), e);
         chk("run_ov", int'(overflow), o);
         chk("run_valid", int'(out_valid), i == 3 ? 1 : 0);
         chk("run_in_ready", int'(in_ready), i == 3 ? 0 : 1);
      end
   endtask

   task automatic run_job(input vec_t v, input int gapmax, input int stall);
      start_job(v.b);
      accumulate(v, gapmax);
      chk("final_acc", int'(acc_out), v.acc);
      chk("final_ov", int'(overflow), v.ov);
      take(stall, v.acc, v.ov, int'(v.b));
   endtask

   initial begin
      tbl[0] = mk(5, 1, 3, -5, 7, 2, 4, 6, -8, -72, 0);
      tbl[1] = mk(-3, 127, 127, 127, 127, 127, 127, 127, 127, 32767, 1);
      tbl[2] = mk(100, -128, -128, -128, -128, 127, 127, 127, 127, -32768, 1);
      tbl[3] = mk(-128, 1, 1, 1, 1, 1, 1, 1, 1, 4, 0);
      tbl[4] = mk(127, 127, 127, 127, -128, 127, 127, 127, 127, 16511, 1);
      tbl[5] = mk(0, -128, -128, -128, 127, 127, 127, 127, 127, -16639, 1);

      repeat (2) @(negedge clk);
      chk("rst_acc", int'(acc_out), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;

      foreach (tbl[i]) run_job(tbl[i], 0, 1);

      // Gappy input stream and a long stall in DONE with start pulses.
      run_job(tbl[0], 2, 5);

      // Reset in the middle of a job, then a clean job.
      start_job(8'sd5);
      feed(8'sd1, 8'sd2, 0);
      feed(8'sd3, 8'sd4, 0);
      chk("pre_rst_acc", int'(acc_out), 14);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_acc", int'(acc_out), 0);
      chk("mid_rst_bias", int'(bias_out), 0);
      chk("mid_rst_in_ready", int'(in_ready), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_valid", int'(out_valid), 0);
      #1 rst = 1'b0;
      run_job(tbl[0], 0, 0);

      // start coinciding with out_ready in DONE is ignored; the next one is taken.
      start_job(8'sd9);
      accumulate(tbl[3], 0);
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("so_valid", int'(out_valid), 0);
      chk("so_busy", int'(busy), 0);
      chk("so_acc_kept", int'(acc_out), 4);
      @(negedge clk);
      start = 1'b0;
      chk("so_restart_busy", int'(busy), 1);
      chk("so_restart_ready", int'(in_ready), 1);
      chk("so_restart_acc", int'(acc_out), 0);
      accumulate(tbl[0], 0);
      take(0, -72, 0, int'(bias_out));

      // Random jobs against the reference model.
      for (int j = 0; j < 30; j++) begin
         vec_t v;
         int e, o;
         v = mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                int'($urandom), int'($urandom), int'($urandom), int'($urandom), 0, 0);
         if (j % 3 == 0)
            for (int k = 0; k < 4; k++) begin
               v.x[k] = (j % 2 == 0) ? 8'h7f : 8'h80;
               v.w[k] = 8'($urandom_range(100, 127));
            end
         ref_model(v, 4, e, o);
         v.acc = e;
         v.ov = o;
         run_job(v, 2, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
